// File: rtl/flagged_sync_fifo_if.sv
// flagged_sync_fifo_if
//   Bundles the request/data/status signals of flagged_sync_fifo.
//   master : producer/consumer side (drives push, pop, data_in, clear_err)
//   slave  : FIFO side (drives data_out, count and all flags)
//   Ports  : none. clk and reset_n are plain ports on the FIFO itself.
interface flagged_sync_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic             clear_err;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, clear_err, data_in,
        input  data_out, count, full, empty, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  push, pop, clear_err, data_in,
        output data_out, count, full, empty, almost_full, almost_empty,
               overflow, underflow
    );
endinterface

// File: rtl/flagged_sync_fifo.sv
// flagged_sync_fifo
//   Single-clock FIFO with occupancy count, almost-full/almost-empty
//   thresholds, push-through when full, sticky overflow/underflow flags and
//   a selectable registered or first-word-fall-through read port.
// Ports:
//   clk      : clock, all state changes on the rising edge
//   reset_n  : synchronous active-low reset (memory contents are kept)
//   bus      : slave side of flagged_sync_fifo_if
//              in : push, pop, data_in, clear_err
//              out: data_out, count, full, empty, almost_full, almost_empty,
//                   overflow, underflow
module flagged_sync_fifo #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    flagged_sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (!((DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) &&
          (AF_LEVEL >= 1) && (AF_LEVEL <= DEPTH) &&
          (AE_LEVEL >= 0) && (AE_LEVEL <= DEPTH - 1))) begin : g_param_check
        $error("flagged_sync_fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic full, empty;
    logic push_ok, pop_ok;

    // Flags depend only on the registered count.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // A push into a full FIFO is taken when the same-cycle pop frees a slot.
    assign pop_ok  = bus.pop & ~empty;
    assign push_ok = bus.push & (~full | pop_ok);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new error event beats a coincident clear.
        if (bus.clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.push & ~push_ok) overflow_d  = 1'b1;
        if (bus.pop  & ~pop_ok)  underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.data_in;
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.data_out = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_reg_read
        logic [WIDTH-1:0] data_out_q, data_out_d;

        // At push-through rd_ptr == wr_ptr; the read sees the pre-write word.
        always_comb begin
            data_out_d = data_out_q;
            if (pop_ok) data_out_d = mem_q[rd_ptr_q];
        end

        always_ff @(posedge clk) begin
            if (!reset_n) data_out_q <= '0;
            else          data_out_q <= data_out_d;
        end

        assign bus.data_out = data_out_q;
    end
endmodule

// File: tb/tb_flagged_sync_fifo.sv
module tb_flagged_sync_fifo;
    logic clk = 1'b0;
    logic reset_n;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    flagged_sync_fifo_if #(.WIDTH(16), .DEPTH(8)) bus0 ();
    flagged_sync_fifo_if #(.WIDTH(16), .DEPTH(8)) bus1 ();

    flagged_sync_fifo #(.DEPTH(8), .WIDTH(16), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2))
        u_reg (.clk(clk), .reset_n(reset_n), .bus(bus0));

    flagged_sync_fifo #(.DEPTH(8), .WIDTH(16), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2))
        u_fwft (.clk(clk), .reset_n(reset_n), .bus(bus1));

    // status = {count[3:0], full, empty, almost_full, almost_empty, overflow, underflow}
    wire [9:0] st0 = {bus0.count, bus0.full, bus0.empty, bus0.almost_full,
                      bus0.almost_empty, bus0.overflow, bus0.underflow};
    wire [9:0] st1 = {bus1.count, bus1.full, bus1.empty, bus1.almost_full,
                      bus1.almost_empty, bus1.overflow, bus1.underflow};

    function automatic logic [9:0] exp_st(input int c, input logic ov, input logic un);
        logic [3:0] cc;
        cc = 4'(c);
        return {cc, (c == 8), (c == 0), (c >= 6), (c <= 2), ov, un};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.push = 0; bus0.pop = 0; bus0.clear_err = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        tick();
        total_cnt++;
        if (st0 !== exp_st(0, 0, 0))
            $display("FAIL reset_status act=%b exp=%b", st0, exp_st(0, 0, 0));
        else pass_cnt++;
        total_cnt++;
        if (bus0.data_out !== 16'h0000)
            $display("FAIL reset_data act=%h exp=%h", bus0.data_out, 16'h0000);
        else pass_cnt++;
        total_cnt++;
        if (st1 !== exp_st(0, 0, 0) || bus1.data_out !== 16'h0000)
            $display("FAIL reset_fwft act=%b/%h exp=%b/%h", st1, bus1.data_out, exp_st(0, 0, 0), 16'h0000);
        else pass_cnt++;
        reset_n = 1;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            bus0.push = 1; bus0.data_in = 16'(i);
            tick();
            total_cnt++;
            if (st0 !== exp_st(i, 0, 0))
                $display("FAIL fill_status_%0d act=%b exp=%b", i, st0, exp_st(i, 0, 0));
            else pass_cnt++;
        end
        idle0();
    endtask

    task automatic test_overflow_drain();
        bus0.push = 1; bus0.data_in = 16'h0009;
        tick();
        idle0();
        total_cnt++;
        if (st0 !== exp_st(8, 1, 0))
            $display("FAIL overflow_status act=%b exp=%b", st0, exp_st(8, 1, 0));
        else pass_cnt++;
        bus0.clear_err = 1;
        tick();
        idle0();
        total_cnt++;
        if (st0 !== exp_st(8, 0, 0))
            $display("FAIL overflow_clear act=%b exp=%b", st0, exp_st(8, 0, 0));
        else pass_cnt++;
        for (int i = 1; i <= 8; i++) begin
            bus0.pop = 1;
            tick();
            total_cnt++;
            if (bus0.data_out !== 16'(i) || st0 !== exp_st(8 - i, 0, 0))
                $display("FAIL drain_%0d act=%h/%b exp=%h/%b", i, bus0.data_out, st0, 16'(i), exp_st(8 - i, 0, 0));
            else pass_cnt++;
        end
        idle0();
    endtask

    task automatic test_push_through();
        logic [15:0] exp_q [$];
        for (int i = 0; i < 8; i++) begin
            bus0.push = 1; bus0.data_in = 16'h0011 + 16'(i);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            bus0.push = 1; bus0.pop = 1; bus0.data_in = 16'h00A0 + 16'(k);
            tick();
            total_cnt++;
            if (bus0.data_out !== 16'h0011 + 16'(k) || st0 !== exp_st(8, 0, 0))
                $display("FAIL push_through_%0d act=%h/%b exp=%h/%b", k, bus0.data_out, st0, 16'h0011 + 16'(k), exp_st(8, 0, 0));
            else pass_cnt++;
        end
        idle0();
        exp_q = '{16'h0015, 16'h0016, 16'h0017, 16'h0018, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        for (int i = 0; i < 8; i++) begin
            bus0.pop = 1;
            tick();
            total_cnt++;
            if (bus0.data_out !== exp_q[i] || st0 !== exp_st(7 - i, 0, 0))
                $display("FAIL wrap_drain_%0d act=%h/%b exp=%h/%b", i, bus0.data_out, st0, exp_q[i], exp_st(7 - i, 0, 0));
            else pass_cnt++;
        end
        idle0();
    endtask

    task automatic test_underflow();
        bus0.pop = 1;
        tick();
        total_cnt++;
        if (st0 !== exp_st(0, 0, 1) || bus0.data_out !== 16'h00A3)
            $display("FAIL underflow_set act=%b/%h exp=%b/%h", st0, bus0.data_out, exp_st(0, 0, 1), 16'h00A3);
        else pass_cnt++;
        bus0.clear_err = 1;
        tick();
        total_cnt++;
        if (bus0.underflow !== 1'b1)
            $display("FAIL underflow_set_wins act=%b exp=%b", bus0.underflow, 1'b1);
        else pass_cnt++;
        bus0.pop = 0;
        tick();
        total_cnt++;
        if (bus0.underflow !== 1'b0)
            $display("FAIL underflow_clear act=%b exp=%b", bus0.underflow, 1'b0);
        else pass_cnt++;
        bus0.clear_err = 0; bus0.push = 1; bus0.pop = 1; bus0.data_in = 16'h0055;
        tick();
        idle0();
        total_cnt++;
        if (st0 !== exp_st(1, 0, 1) || bus0.data_out !== 16'h00A3)
            $display("FAIL push_pop_empty act=%b/%h exp=%b/%h", st0, bus0.data_out, exp_st(1, 0, 1), 16'h00A3);
        else pass_cnt++;
        bus0.clear_err = 1;
        tick();
        bus0.clear_err = 0; bus0.pop = 1;
        tick();
        idle0();
        total_cnt++;
        if (st0 !== exp_st(0, 0, 0) || bus0.data_out !== 16'h0055)
            $display("FAIL push_pop_empty_read act=%b/%h exp=%b/%h", st0, bus0.data_out, exp_st(0, 0, 0), 16'h0055);
        else pass_cnt++;
    endtask

    task automatic test_fwft();
        bus1.push = 1; bus1.data_in = 16'h1234;
        tick();
        bus1.push = 0;
        total_cnt++;
        if (bus1.data_out !== 16'h1234 || st1 !== exp_st(1, 0, 0))
            $display("FAIL fwft_first act=%h/%b exp=%h/%b", bus1.data_out, st1, 16'h1234, exp_st(1, 0, 0));
        else pass_cnt++;
        bus1.push = 1; bus1.data_in = 16'h5678;
        tick();
        bus1.push = 0;
        total_cnt++;
        if (bus1.data_out !== 16'h1234 || st1 !== exp_st(2, 0, 0))
            $display("FAIL fwft_hold act=%h/%b exp=%h/%b", bus1.data_out, st1, 16'h1234, exp_st(2, 0, 0));
        else pass_cnt++;
        bus1.pop = 1;
        tick();
        bus1.pop = 0;
        total_cnt++;
        if (bus1.data_out !== 16'h5678 || st1 !== exp_st(1, 0, 0))
            $display("FAIL fwft_pop act=%h/%b exp=%h/%b", bus1.data_out, st1, 16'h5678, exp_st(1, 0, 0));
        else pass_cnt++;
        bus1.pop = 1;
        tick();
        bus1.pop = 0;
        total_cnt++;
        if (bus1.data_out !== 16'h0000 || st1 !== exp_st(0, 0, 0))
            $display("FAIL fwft_empty act=%h/%b exp=%h/%b", bus1.data_out, st1, 16'h0000, exp_st(0, 0, 0));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus0.pop = 1;
        tick();
        idle0();
        for (int i = 0; i < 5; i++) begin
            bus0.push = 1; bus0.data_in = 16'h0100 + 16'(i);
            tick();
        end
        total_cnt++;
        if (st0 !== exp_st(5, 0, 1))
            $display("FAIL pre_reset_status act=%b exp=%b", st0, exp_st(5, 0, 1));
        else pass_cnt++;
        reset_n = 0; bus0.push = 1; bus0.pop = 1; bus0.data_in = 16'hDEAD;
        tick();
        reset_n = 1;
        idle0();
        total_cnt++;
        if (st0 !== exp_st(0, 0, 0) || bus0.data_out !== 16'h0000)
            $display("FAIL mid_reset act=%b/%h exp=%b/%h", st0, bus0.data_out, exp_st(0, 0, 0), 16'h0000);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            bus0.push = 1; bus0.data_in = 16'h0200 + 16'(i);
            tick();
        end
        idle0();
        for (int i = 0; i < 2; i++) begin
            bus0.pop = 1;
            tick();
            total_cnt++;
            if (bus0.data_out !== 16'h0200 + 16'(i) || st0 !== exp_st(1 - i, 0, 0))
                $display("FAIL post_reset_read_%0d act=%h/%b exp=%h/%b", i, bus0.data_out, st0, 16'h0200 + 16'(i), exp_st(1 - i, 0, 0));
            else pass_cnt++;
        end
        idle0();
    endtask

    initial begin
        reset_n = 0;
        bus0.push = 0; bus0.pop = 0; bus0.clear_err = 0; bus0.data_in = '0;
        bus1.push = 0; bus1.pop = 0; bus1.clear_err = 0; bus1.data_in = '0;
        test_reset();
        test_fill();
        test_overflow_drain();
        test_push_through();
        test_underflow();
        test_fwft();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
